pipeline_watchdog: RTL and testbench

Synthesizable progress monitor for the out-of-order core that generalises the bench-side "PC unchanged for N cycles" end/deadlock detection. It watches the fetch PC and up to LANES retire lanes, and flags a warning and then a sticky hang after configurable stall thresholds. It also keeps saturating commit, flush and cycle counters. It sits beside `top_processor` inside `module_top` and feeds status registers and the bench's end-of-simulation detection.

---
 rtl/pipeline_watchdog_if.sv | 25 ++
 rtl/pipeline_watchdog.sv | 148 ++++++++++++++
 tb/tb_pipeline_watchdog.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_watchdog_if.sv
// Observation bundle for the pipeline watchdog: fetch PC, per-lane retire
// status and flush events as seen from the core.
interface pipeline_watchdog_if #(
  parameter int PC_W  = 32,
  parameter int LANES = 2
);
  logic [PC_W-1:0]  pc_i;
  logic [LANES-1:0] commit_valid_i;
  logic [LANES-1:0] commit_flushed_i;
  logic             flush_valid_i;

  modport master (
    output pc_i,
    output commit_valid_i,
    output commit_flushed_i,
    output flush_valid_i
  );

  modport slave (
    input pc_i,
    input commit_valid_i,
    input commit_flushed_i,
    input flush_valid_i
  );
endinterface

// File: rtl/pipeline_watchdog.sv
// Progress monitor: flags WARN then a sticky HUNG when neither the fetch PC
// nor (optionally) good commits advance, and keeps saturating activity counters.
module pipeline_watchdog #(
  parameter int PC_W          = 32,
  parameter int LANES         = 2,
  parameter int TIMEOUT       = 500,
  parameter int WARN_CYC      = 250,
  parameter int CNT_W         = 32,
  parameter int PROGRESS_MODE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable_i,
  input  logic                         clear_i,
  pipeline_watchdog_if.slave           mon,
  output logic [1:0]                   state_o,
  output logic                         warn_o,
  output logic                         hung_o,
  output logic [$clog2(TIMEOUT+1)-1:0] stall_cnt_o,
  output logic [PC_W-1:0]              last_pc_o,
  output logic [CNT_W-1:0]             commit_cnt_o,
  output logic [CNT_W-1:0]             flush_cnt_o,
  output logic [CNT_W-1:0]             cycle_cnt_o
);

  localparam int SW = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 2 || WARN_CYC < 1 || WARN_CYC >= TIMEOUT || LANES < 1) begin : g_badParams
    $error("pipeline_watchdog: illegal TIMEOUT/WARN_CYC/LANES combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_WARN  = 2'd2,
    S_HUNG  = 2'd3
  } state_t;

  state_t            r_state, w_nextState;
  logic [SW-1:0]     r_stallCnt, w_nextStall, w_stallInc;
  logic [PC_W-1:0]   r_lastPc, w_nextLastPc;
  logic [CNT_W-1:0]  r_commitCnt, w_nextCommit;
  logic [CNT_W-1:0]  r_flushCnt, w_nextFlush;
  logic [CNT_W-1:0]  r_cycleCnt, w_nextCycle;
  logic [LANES-1:0]  w_good;
  logic [CNT_W:0]    w_nCommit;
  logic              w_progress;

  // Sum one extra bit wide so an overflow clamps to all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W:0]   inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + inc;
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  assign w_good     = mon.commit_valid_i & ~mon.commit_flushed_i;
  assign w_progress = (mon.pc_i != r_lastPc) | ((PROGRESS_MODE != 0) & (|w_good));
  assign w_stallInc = r_stallCnt + SW'(1);

  always_comb begin
    w_nCommit = '0;
    for (int i = 0; i < LANES; i++) begin
      w_nCommit = w_nCommit + (CNT_W+1)'(w_good[i]);
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextStall  = r_stallCnt;
    w_nextLastPc = r_lastPc;
    w_nextCommit = r_commitCnt;
    w_nextFlush  = r_flushCnt;
    w_nextCycle  = r_cycleCnt;
    if (clear_i) begin
      w_nextState  = enable_i ? S_ARMED : S_IDLE;
      w_nextStall  = '0;
      w_nextLastPc = '0;
      w_nextCommit = '0;
      w_nextFlush  = '0;
      w_nextCycle  = '0;
    end else if (!enable_i) begin
      w_nextState = S_IDLE;
      w_nextStall = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_nextState  = S_ARMED;
          w_nextStall  = '0;
          w_nextLastPc = mon.pc_i;
        end
        S_ARMED, S_WARN: begin
          w_nextCommit = satAdd(r_commitCnt, w_nCommit);
          w_nextFlush  = satAdd(r_flushCnt, (CNT_W+1)'(mon.flush_valid_i));
          w_nextCycle  = satAdd(r_cycleCnt, (CNT_W+1)'(1));
          if (w_progress) begin
            w_nextState  = S_ARMED;
            w_nextStall  = '0;
            w_nextLastPc = mon.pc_i;
          end else begin
            w_nextStall = w_stallInc;
            if (w_stallInc == SW'(TIMEOUT)) begin
              w_nextState = S_HUNG;
            end else if (w_stallInc >= SW'(WARN_CYC)) begin
              w_nextState = S_WARN;
            end else begin
              w_nextState = S_ARMED;
            end
          end
        end
        S_HUNG: begin
          w_nextState = S_HUNG;
        end
        default: begin
          w_nextState = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_stallCnt  <= '0;
      r_lastPc    <= '0;
      r_commitCnt <= '0;
      r_flushCnt  <= '0;
      r_cycleCnt  <= '0;
    end else begin
      r_state     <= w_nextState;
      r_stallCnt  <= w_nextStall;
      r_lastPc    <= w_nextLastPc;
      r_commitCnt <= w_nextCommit;
      r_flushCnt  <= w_nextFlush;
      r_cycleCnt  <= w_nextCycle;
    end
  end

  assign state_o      = r_state;
  assign warn_o       = (r_state == S_WARN);
  assign hung_o       = (r_state == S_HUNG);
  assign stall_cnt_o  = r_stallCnt;
  assign last_pc_o    = r_lastPc;
  assign commit_cnt_o = r_commitCnt;
  assign flush_cnt_o  = r_flushCnt;
  assign cycle_cnt_o  = r_cycleCnt;

endmodule

// File: tb/tb_pipeline_watchdog.sv
// Directed bench: three watchdog copies (commit-progress, PC-only progress,
// 4-bit counters) share one stimulus stream and are checked against hand values.
module tb_pipeline_watchdog;

  localparam int SW = $clog2(8 + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic clear;

  int nCompared   = 0;
  int nMismatched = 0;

  pipeline_watchdog_if #(.PC_W(32), .LANES(2)) bus ();

  logic [1:0]    mState, zState, sState;
  logic          mWarn, zWarn, sWarn, mHung, zHung, sHung;
  logic [SW-1:0] mStall, zStall, sStall;
  logic [31:0]   mLastPc, zLastPc, sLastPc;
  logic [31:0]   mCommit, mFlush, mCycle, zCommit, zFlush, zCycle;
  logic [3:0]    sCommit, sFlush, sCycle;

  pipeline_watchdog #(.PC_W(32), .LANES(2), .TIMEOUT(8), .WARN_CYC(4), .CNT_W(32), .PROGRESS_MODE(1)) dutMain (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .clear_i(clear), .mon(bus),
    .state_o(mState), .warn_o(mWarn), .hung_o(mHung), .stall_cnt_o(mStall), .last_pc_o(mLastPc),
    .commit_cnt_o(mCommit), .flush_cnt_o(mFlush), .cycle_cnt_o(mCycle)
  );

  pipeline_watchdog #(.PC_W(32), .LANES(2), .TIMEOUT(8), .WARN_CYC(4), .CNT_W(32), .PROGRESS_MODE(0)) dutPcOnly (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .clear_i(clear), .mon(bus),
    .state_o(zState), .warn_o(zWarn), .hung_o(zHung), .stall_cnt_o(zStall), .last_pc_o(zLastPc),
    .commit_cnt_o(zCommit), .flush_cnt_o(zFlush), .cycle_cnt_o(zCycle)
  );

  pipeline_watchdog #(.PC_W(32), .LANES(2), .TIMEOUT(8), .WARN_CYC(4), .CNT_W(4), .PROGRESS_MODE(1)) dutSmall (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .clear_i(clear), .mon(bus),
    .state_o(sState), .warn_o(sWarn), .hung_o(sHung), .stall_cnt_o(sStall), .last_pc_o(sLastPc),
    .commit_cnt_o(sCommit), .flush_cnt_o(sFlush), .cycle_cnt_o(sCycle)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input int edges);
    repeat (edges) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    clear = 1'b0;
    bus.pc_i = 32'h100;
    bus.commit_valid_i = 2'b00;
    bus.commit_flushed_i = 2'b00;
    bus.flush_valid_i = 1'b0;
    #12;
    checkOutput("rst_state", mState, 0);
    checkOutput("rst_warn", mWarn, 0);
    checkOutput("rst_hung", mHung, 0);
    checkOutput("rst_commit", mCommit, 0);
    checkOutput("rst_lastpc", mLastPc, 0);
    rst_n = 1'b1;

    // Frozen PC, no commits: WARN after 4 stalled edges, HUNG after 8
    enable = 1'b1;
    applyStimulus(1);
    checkOutput("arm_state", mState, 1);
    checkOutput("arm_lastpc", mLastPc, 32'h100);
    applyStimulus(3);
    checkOutput("pre_warn", mWarn, 0);
    checkOutput("pre_warn_stall", mStall, 3);
    applyStimulus(1);
    checkOutput("warn_rise", mWarn, 1);
    checkOutput("warn_state", mState, 2);
    applyStimulus(3);
    checkOutput("pre_hung", mHung, 0);
    applyStimulus(1);
    checkOutput("hung_rise", mHung, 1);
    checkOutput("hung_stall", mStall, 8);
    checkOutput("hung_cycle", mCycle, 8);

    // Activity while HUNG must not move anything
    bus.pc_i = 32'h200;
    bus.commit_valid_i = 2'b11;
    bus.flush_valid_i = 1'b1;
    applyStimulus(3);
    checkOutput("frz_state", mState, 3);
    checkOutput("frz_stall", mStall, 8);
    checkOutput("frz_lastpc", mLastPc, 32'h100);
    checkOutput("frz_commit", mCommit, 0);
    checkOutput("frz_flush", mFlush, 0);
    checkOutput("frz_cycle", mCycle, 8);

    bus.pc_i = 32'h100;
    bus.commit_valid_i = 2'b00;
    bus.flush_valid_i = 1'b0;
    clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0;
    checkOutput("clr_state", mState, 1);
    checkOutput("clr_hung", mHung, 0);
    checkOutput("clr_cycle", mCycle, 0);
    checkOutput("clr_lastpc", mLastPc, 0);

    // Frozen PC with two-lane commits every 3rd edge
    for (int k = 1; k <= 12; k++) begin
      bus.commit_valid_i = (k % 3 == 0) ? 2'b11 : 2'b00;
      applyStimulus(1);
      if (k % 3 == 0) checkOutput($sformatf("cmt_cnt_%0d", k), mCommit, 2 * (k / 3));
    end
    bus.commit_valid_i = 2'b00;
    checkOutput("cmt_state", mState, 1);
    checkOutput("cmt_cycle", mCycle, 12);
    checkOutput("pconly_hung", zHung, 1);
    checkOutput("pconly_stall", zStall, 8);
    checkOutput("pconly_commit", zCommit, 6);

    // Lane 1 flushed: one good commit per edge; five flush pulses
    bus.commit_valid_i = 2'b11;
    bus.commit_flushed_i = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      bus.flush_valid_i = k[0];
      applyStimulus(1);
      if (k == 1) checkOutput("fl_commit_1", mCommit, 9);
    end
    bus.flush_valid_i = 1'b0;
    checkOutput("fl_commit", mCommit, 18);
    checkOutput("fl_flush", mFlush, 5);
    checkOutput("fl_stall", mStall, 0);
    checkOutput("sat_commit", sCommit, 15);
    checkOutput("sat_cycle", sCycle, 15);
    checkOutput("sat_flush", sFlush, 5);

    // Clear and enable falling together: clear wins, state IDLE
    bus.commit_valid_i = 2'b00;
    bus.commit_flushed_i = 2'b00;
    clear = 1'b1;
    enable = 1'b0;
    applyStimulus(1);
    clear = 1'b0;
    checkOutput("clrdis_state", mState, 0);
    checkOutput("clrdis_commit", mCommit, 0);
    checkOutput("clrdis_flush", mFlush, 0);
    checkOutput("clrdis_small", sCommit, 0);

    // Both lanes good every edge; the arming edge does not count
    enable = 1'b1;
    bus.commit_valid_i = 2'b11;
    applyStimulus(8);
    checkOutput("sat2_14", sCommit, 14);
    applyStimulus(1);
    checkOutput("sat2_15", sCommit, 15);
    applyStimulus(1);
    checkOutput("sat2_hold", sCommit, 15);
    checkOutput("sat2_main", mCommit, 18);

    bus.commit_valid_i = 2'b00;
    enable = 1'b0;
    applyStimulus(1);
    checkOutput("dis_state", mState, 0);
    checkOutput("dis_commit", mCommit, 18);
    checkOutput("dis_cycle", mCycle, 9);
    checkOutput("dis_stall", mStall, 0);

    // A single progress edge drops WARN
    enable = 1'b1;
    applyStimulus(5);
    checkOutput("w2_warn", mWarn, 1);
    bus.pc_i = 32'h104;
    applyStimulus(1);
    checkOutput("w2_drop", mWarn, 0);
    checkOutput("w2_lastpc", mLastPc, 32'h104);
    checkOutput("w2_stall", mStall, 0);
    applyStimulus(4);
    checkOutput("w3_warn", mWarn, 1);

    // Asynchronous reset from WARN
    rst_n = 1'b0;
    #2;
    checkOutput("arst_state", mState, 0);
    checkOutput("arst_warn", mWarn, 0);
    checkOutput("arst_commit", mCommit, 0);
    checkOutput("arst_cycle", mCycle, 0);
    checkOutput("arst_lastpc", mLastPc, 0);
    enable = 1'b0;
    rst_n = 1'b1;
    applyStimulus(2);
    checkOutput("post_rst_idle", mState, 0);
    enable = 1'b1;
    applyStimulus(1);
    checkOutput("post_rst_arm", mState, 1);
    checkOutput("post_rst_lastpc", mLastPc, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
